// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with one in-flight request and a two-entry buffer
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam int CntW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]     pcQ;
    logic            inflightQ;
    logic [31:0]     inflightPcQ;
    logic [31:0]     headInstrQ;
    logic [31:0]     headPcQ;
    logic [31:0]     tailInstrQ;
    logic [31:0]     tailPcQ;
    logic [CntW-1:0] countQ;
    logic            misalignQ;
    logic [31:0]     fetchCountQ;

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occupancy;

    // Redirect squashes both the consumer side and the returning response.
    always_comb begin
        pop       = (countQ != '0) && !stall && !redirect_valid;
        push      = inflightQ && !redirect_valid;
        occupancy = 3'(countQ) + 3'(inflightQ) - 3'(pop);
        issue     = !reset && !redirect_valid && (occupancy <= 3'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcQ         <= RESET_PC;
            countQ      <= '0;
            inflightQ   <= 1'b0;
            misalignQ   <= 1'b0;
            fetchCountQ <= '0;
        end else if (redirect_valid) begin
            pcQ       <= {redirect_pc[31:2], 2'b00};
            countQ    <= '0;
            inflightQ <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalignQ <= 1'b1;
            end
        end else begin
            inflightQ <= issue;
            if (issue) begin
                pcQ         <= pcQ + 32'd4;
                inflightPcQ <= pcQ;
            end
            if (pop) begin
                fetchCountQ <= fetchCountQ + 32'd1;
            end
            // The head always holds the oldest entry; the tail only matters when count is 2.
            case ({push, pop})
                2'b11: begin
                    if (countQ == CntW'(1)) begin
                        headInstrQ <= imem_rdata;
                        headPcQ    <= inflightPcQ;
                    end else begin
                        headInstrQ <= tailInstrQ;
                        headPcQ    <= tailPcQ;
                        tailInstrQ <= imem_rdata;
                        tailPcQ    <= inflightPcQ;
                    end
                end
                2'b10: begin
                    if (countQ == '0) begin
                        headInstrQ <= imem_rdata;
                        headPcQ    <= inflightPcQ;
                    end else begin
                        tailInstrQ <= imem_rdata;
                        tailPcQ    <= inflightPcQ;
                    end
                    countQ <= countQ + CntW'(1);
                end
                2'b01: begin
                    headInstrQ <= tailInstrQ;
                    headPcQ    <= tailPcQ;
                    countQ     <= countQ - CntW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_en      = issue;
    assign imem_addr    = pcQ;
    assign if_valid     = (countQ != '0);
    assign if_instr     = headInstrQ;
    assign if_pc        = headPcQ;
    assign if_pc4       = headPcQ + 32'd4;
    assign misalign_err = misalignQ;
    assign fetch_count  = fetchCountQ;

endmodule
